// File: rtl/be_seq_ctrl_if.sv
// be_seq_ctrl_if: equalizer configuration handshake between the tap producer and be_seq_ctrl.
// Signals: i_cfg_valid (producer offers taps), i_cfg_hm1/i_cfg_hp1/i_cfg_hx (8-bit offered taps),
//          o_cfg_ready (controller accepts the offer this cycle).
// Modports: master = tap producer, slave = be_seq_ctrl.
interface be_seq_ctrl_if;
  logic       i_cfg_valid;
  logic [7:0] i_cfg_hm1;
  logic [7:0] i_cfg_hp1;
  logic [7:0] i_cfg_hx;
  logic       o_cfg_ready;
  modport master (output i_cfg_valid, i_cfg_hm1, i_cfg_hp1, i_cfg_hx, input o_cfg_ready);
  modport slave (input i_cfg_valid, i_cfg_hm1, i_cfg_hp1, i_cfg_hx, output o_cfg_ready);
endinterface

// File: rtl/be_seq_ctrl.sv
// be_seq_ctrl: backend bring-up sequencer (enable, stage reset, tap configuration, pipeline flush, run).
// Ports: i_clk_dig_be clock; i_rstb_dig_be async active-low reset; i_start/i_stop one-cycle pulses;
//        cfg_bus configuration handshake (slave); o_en_* stage enables; o_rst_* stage resets;
//        o_eq_* applied taps; o_busy sequence in progress; o_drx_valid receive data trustworthy.
module be_seq_ctrl #(
  parameter int RST_CYCLES   = 4,
  parameter int FLUSH_CYCLES = 8
) (
  input  logic              i_clk_dig_be,
  input  logic              i_rstb_dig_be,
  input  logic              i_start,
  input  logic              i_stop,
  be_seq_ctrl_if.slave      cfg_bus,
  output logic              o_en_alu,
  output logic              o_en_filt,
  output logic              o_en_dec,
  output logic              o_rst_alu,
  output logic              o_rst_filt,
  output logic              o_rst_dec,
  output logic [7:0]        o_eq_hm1,
  output logic [7:0]        o_eq_hp1,
  output logic [7:0]        o_eq_hx,
  output logic              o_busy,
  output logic              o_drx_valid
);
  typedef enum logic [2:0] {S_IDLE, S_ENABLE, S_RESET, S_CFG, S_FLUSH, S_RUN} state_t;
  localparam logic [7:0] RST_LAST   = 8'(RST_CYCLES - 1);
  localparam logic [7:0] FLUSH_LAST = 8'(FLUSH_CYCLES - 1);
  state_t     r_state, w_next;
  logic [7:0] r_cnt, w_cnt_next;
  logic       w_ready, w_acc;
  logic       r_en, r_rst, r_busy, r_drx;
  logic [7:0] r_eq_hm1, r_eq_hp1, r_eq_hx;
  assign w_ready = (r_state == S_CFG) || (r_state == S_RUN);
  // A stop in the same cycle cancels the acceptance so the taps are retained.
  assign w_acc = w_ready && cfg_bus.i_cfg_valid && !i_stop;
  assign cfg_bus.o_cfg_ready = w_ready;
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   w_next = i_start ? S_ENABLE : S_IDLE;
      S_ENABLE: w_next = S_RESET;
      S_RESET:  w_next = (r_cnt >= RST_LAST) ? S_CFG : S_RESET;
      S_CFG:    w_next = w_acc ? S_FLUSH : S_CFG;
      S_FLUSH:  w_next = (r_cnt >= FLUSH_LAST) ? S_RUN : S_FLUSH;
      S_RUN:    w_next = w_acc ? S_FLUSH : S_RUN;
      default:  w_next = S_IDLE;
    endcase
    if (i_stop) w_next = S_IDLE;
    // Counter restarts on every state change (including RUN->FLUSH) and saturates at 8'hFF.
    w_cnt_next = (w_next != r_state) ? 8'd0 : (&r_cnt ? r_cnt : r_cnt + 8'd1);
  end
  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge i_clk_dig_be or negedge i_rstb_dig_be) begin
    if (!i_rstb_dig_be) begin
      r_state  <= S_IDLE;
      r_cnt    <= 8'd0;
      r_en     <= 1'b0;
      r_rst    <= 1'b0;
      r_busy   <= 1'b0;
      r_drx    <= 1'b0;
      r_eq_hm1 <= 8'h00;
      r_eq_hp1 <= 8'h00;
      r_eq_hx  <= 8'h00;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
      r_en    <= w_next != S_IDLE;
      r_rst   <= w_next == S_RESET;
      r_busy  <= w_next inside {S_ENABLE, S_RESET, S_CFG, S_FLUSH};
      r_drx   <= w_next == S_RUN;
      if (w_acc) begin
        r_eq_hm1 <= cfg_bus.i_cfg_hm1;
        r_eq_hp1 <= cfg_bus.i_cfg_hp1;
        r_eq_hx  <= cfg_bus.i_cfg_hx;
      end
    end
  end
  assign o_en_alu    = r_en;
  assign o_en_filt   = r_en;
  assign o_en_dec    = r_en;
  assign o_rst_alu   = r_rst;
  assign o_rst_filt  = r_rst;
  assign o_rst_dec   = r_rst;
  assign o_busy      = r_busy;
  assign o_drx_valid = r_drx;
  assign o_eq_hm1    = r_eq_hm1;
  assign o_eq_hp1    = r_eq_hp1;
  assign o_eq_hx     = r_eq_hx;
endmodule

// File: tb/tb_be_seq_ctrl.sv
// tb_be_seq_ctrl: directed scenarios plus random pulses, checked every cycle against a phase/countdown model.
module tb_be_seq_ctrl;
  logic clk = 1'b0, rstn = 1'b1, start = 1'b0, stop = 1'b0;
  logic en_alu, en_filt, en_dec, rst_alu, rst_filt, rst_dec, busy, drx;
  logic [7:0] eq_hm1, eq_hp1, eq_hx;
  be_seq_ctrl_if bus();
  be_seq_ctrl #(.RST_CYCLES(4), .FLUSH_CYCLES(8)) dut (
    .i_clk_dig_be(clk), .i_rstb_dig_be(rstn), .i_start(start), .i_stop(stop), .cfg_bus(bus),
    .o_en_alu(en_alu), .o_en_filt(en_filt), .o_en_dec(en_dec),
    .o_rst_alu(rst_alu), .o_rst_filt(rst_filt), .o_rst_dec(rst_dec),
    .o_eq_hm1(eq_hm1), .o_eq_hp1(eq_hp1), .o_eq_hx(eq_hx),
    .o_busy(busy), .o_drx_valid(drx)
  );
  always #5 clk = ~clk;
  // Model phases: 0 idle, 1 enable, 2 reset, 3 cfg, 4 flush, 5 run; m_left = cycles remaining in a timed phase.
  int m_phase, m_left;
  logic [7:0] m_eq [3];
  int n_chk = 0, n_fail = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic model_reset();
    m_phase = 0;
    m_left = 0;
    m_eq[0] = 8'h00;
    m_eq[1] = 8'h00;
    m_eq[2] = 8'h00;
  endtask
  task automatic model_step();
    if (!rstn) model_reset();
    else if (stop) m_phase = 0;
    else if (m_phase == 0) m_phase = start ? 1 : 0;
    else if (m_phase == 1) begin
      m_phase = 2;
      m_left = 4;
    end else if (m_phase == 2 || m_phase == 4) begin
      m_left--;
      if (m_left == 0) m_phase++;
    end else if (bus.i_cfg_valid) begin
      m_eq[0] = bus.i_cfg_hm1;
      m_eq[1] = bus.i_cfg_hp1;
      m_eq[2] = bus.i_cfg_hx;
      m_phase = 4;
      m_left = 8;
    end
  endtask
  function automatic logic [32:0] model_out();
    logic en, rs, bz, dv, rd;
    en = m_phase != 0;
    rs = m_phase == 2;
    bz = m_phase >= 1 && m_phase <= 4;
    dv = m_phase == 5;
    rd = m_phase == 3 || m_phase == 5;
    return {en, en, en, rs, rs, rs, bz, dv, rd, m_eq[0], m_eq[1], m_eq[2]};
  endfunction
  function automatic logic [32:0] dut_out();
    return {en_alu, en_filt, en_dec, rst_alu, rst_filt, rst_dec, busy, drx, bus.o_cfg_ready, eq_hm1, eq_hp1, eq_hx};
  endfunction
  initial forever begin
    @(negedge clk);
    chk("cycle_outputs", 64'(dut_out()), 64'(model_out()));
  end
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask
  task automatic offer(input logic v, input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    bus.i_cfg_valid = v;
    bus.i_cfg_hm1 = a;
    bus.i_cfg_hp1 = b;
    bus.i_cfg_hx = c;
  endtask
  task automatic chk_eq(input string name, input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    chk(name, {eq_hm1, eq_hp1, eq_hx}, {a, b, c});
  endtask
  // Start with the configuration already offered; expect 4 reset cycles and RUN 14 cycles after ENABLE.
  task automatic bringup(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    int n, nrst;
    logic acc;
    offer(1'b1, a, b, c);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("enable_en", {en_alu, en_filt, en_dec, busy, rst_alu}, 5'b11110);
    n = 0;
    nrst = 0;
    while (!drx && n < 100) begin
      acc = bus.o_cfg_ready && bus.i_cfg_valid;
      tick();
      n++;
      if (acc) bus.i_cfg_valid = 1'b0;
      if (rst_alu) nrst++;
    end
    chk("drx_latency", n, 14);
    chk("rst_len", nrst, 4);
    chk_eq("bringup_eq", a, b, c);
    chk("run_busy", busy, 0);
  endtask
  initial begin
    int n, low;
    logic seen, hold_ok;
    model_reset();
    offer(1'b0, 8'h00, 8'h00, 8'h00);
    #1 rstn = 1'b0;
    #2;
    chk("reset_async", 64'(dut_out()), 64'd0);
    tick();
    tick();
    rstn = 1'b1;
    tick();
    chk("idle_after_reset", {en_alu, busy, drx}, 3'b000);
    // nominal bring-up
    bringup(8'h18, 8'h18, 8'h21);
    // RUN reconfiguration
    offer(1'b1, 8'h10, 8'h0C, 8'h20);
    tick();
    bus.i_cfg_valid = 1'b0;
    chk("reconf_drx_low", drx, 0);
    chk_eq("reconf_eq", 8'h10, 8'h0C, 8'h20);
    low = 1;
    seen = 1'b0;
    while (!drx && low < 50) begin
      tick();
      if (!drx) low++;
      seen |= rst_alu;
    end
    chk("reconf_low_len", low, 8);
    chk("reconf_no_rst", seen, 0);
    // simultaneous stop and config in RUN
    offer(1'b1, 8'hAA, 8'hBB, 8'hCC);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    bus.i_cfg_valid = 1'b0;
    chk("stop_vs_cfg_state", {en_alu, busy, drx, bus.o_cfg_ready}, 4'b0000);
    chk_eq("stop_vs_cfg_eq", 8'h10, 8'h0C, 8'h20);
    // late configuration
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (!bus.o_cfg_ready && n < 20) begin
      tick();
      n++;
    end
    chk("late_cfg_reach", n, 5);
    hold_ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      hold_ok &= bus.o_cfg_ready && busy && !drx;
    end
    chk("late_cfg_hold", hold_ok, 1);
    offer(1'b1, 8'h21, 8'h22, 8'h23);
    tick();
    bus.i_cfg_valid = 1'b0;
    chk("late_accept", {busy, drx, bus.o_cfg_ready}, 3'b100);
    n = 0;
    while (!drx && n < 50) begin
      tick();
      n++;
    end
    chk("late_flush_len", n, 8);
    // abort during RESET
    stop = 1'b1;
    tick();
    stop = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("in_reset", rst_alu, 1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("abort_reset", {en_alu, en_filt, en_dec, rst_alu, busy}, 5'b00000);
    chk_eq("abort_reset_eq", 8'h21, 8'h22, 8'h23);
    // abort during FLUSH
    offer(1'b1, 8'h33, 8'h44, 8'h55);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    bus.i_cfg_valid = 1'b0;
    chk("in_flush", {busy, drx}, 2'b10);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("abort_flush", {en_alu, busy, drx}, 3'b000);
    chk_eq("abort_flush_eq", 8'h33, 8'h44, 8'h55);
    // async reset mid-FLUSH
    offer(1'b1, 8'h66, 8'h77, 8'h88);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    bus.i_cfg_valid = 1'b0;
    #2 rstn = 1'b0;
    model_reset();
    #1;
    chk("reset_mid_flush", 64'(dut_out()), 64'd0);
    tick();
    rstn = 1'b1;
    tick();
    tick();
    chk("idle_after_mid_reset", {en_alu, busy}, 2'b00);
    bringup(8'h05, 8'h06, 8'h07);
    // random pulses and offers
    for (int i = 0; i < 1500; i++) begin
      start = $urandom_range(0, 7) == 0;
      stop = $urandom_range(0, 63) == 0;
      offer($urandom_range(0, 2) == 0, 8'($urandom), 8'($urandom), 8'($urandom));
      tick();
    end
    start = 1'b0;
    stop = 1'b0;
    bus.i_cfg_valid = 1'b0;
    tick();
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
